// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional
// 2-entry skid buffer and stall/bubble performance counters.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    bubble_q, bubble_d;

    logic                main_valid;
    logic                skid_valid;
    logic                in_fire;
    logic                out_fire;

    // Slot validity is fully encoded by the state.
    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_FULL);

    // SKID=1 ready depends only on held state; SKID=0 passes out_ready through.
    generate
        if (SKID != 0) begin : g_ready_skid
            always_comb begin
                in_ready = ~skid_valid & ~flush;
            end
        end else begin : g_ready_pass
            always_comb begin
                in_ready = (~main_valid | out_ready) & ~flush;
            end
        end
    endgenerate

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State and data registers; data survives flush, only reset zeroes it.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q  <= ST_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    // Next-state and slot data; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_HALF;
                        main_d  = in_data;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Skid entry is younger, so it only moves up once main drains.
                    if (out_fire) begin
                        state_d = ST_HALF;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (!out_valid && out_ready && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    // Output decode from held state.
    always_comb begin
        out_valid = main_valid & ~flush;
        unique case (state_q)
            ST_HALF: occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_data   = main_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register; the next generation of the if_id / id_ex / ex_mem / mem_wb registers.
- Adds a valid/ready handshake, backpressure, flush (for branch redirect), an optional 2-entry skid buffer and stall/bubble performance counters.
- One instance sits between each pair of stages.
- The stage payload is concatenated by the parent into a single in_data bus.

Parameters:
- DATA_W, 64: payload width in bits (any value >= 1).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready pass-through.
- CNT_W, 32: width of the performance counters.

Ports:
- sys_clk, input, 1: clock; all state updates on the rising edge.
- sys_rst, input, 1: synchronous active-low reset.
- flush, input, 1: discard all held entries this cycle.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept the entry.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: entry available downstream.
- out_ready, input, 1: downstream accepts the entry.
- out_data, output, DATA_W: downstream payload.
- occupancy, output, 2: number of held entries (0..2).
- stall_cnt, output, CNT_W: cycles with out_valid=1 and out_ready=0.
- bubble_cnt, output, CNT_W: cycles with out_valid=0 and out_ready=1.

Behaviour:
- Reset (sys_rst=0 at the clock edge):
  - main and skid slots become invalid; their data registers go to 0.
  - Counters go to 0; state goes to EMPTY.
- Outputs after reset: out_valid=0, out_data=0, occupancy=0, in_ready=1 (SKID=1) or in_ready=1 (SKID=0), stall_cnt=bubble_cnt=0.
- A reset mid-operation discards everything with no drain.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid and in_data must stay stable until in_fire; the bench checks this and the block does not rely on it.
- out_data is always the main slot, so it is registered. out_valid = main_valid & ~flush.
- Latency: an entry accepted at edge N appears at out_valid/out_data from edge N (visible in the cycle after acceptance). Zero-bubble throughput is 1 entry/cycle.
- FSM with SKID=1:
  - EMPTY: in_ready=1.
    - in_fire → HALF, main<=in_data.
  - HALF: in_ready=1.
    - in_fire & out_fire → HALF, main<=in_data.
    - in_fire & ~out_fire → FULL, skid<=in_data.
    - ~in_fire & out_fire → EMPTY.
    - Otherwise hold.
  - FULL: in_ready=0.
    - out_fire → HALF, main<=skid.
    - Otherwise hold.
  - SKID=1 in_ready is a pure register output: ~skid_valid & ~flush. There is no combinational path from out_ready.
- FSM with SKID=0: only EMPTY and HALF exist.
  - in_ready = (~main_valid | out_ready) & ~flush, combinational from out_ready.
  - HALF with in_fire & out_fire → HALF with new data.
- Flush:
  - Takes priority over every transition except reset.
  - Next state is EMPTY; both slots are invalidated; data registers are left unchanged.
  - During the flush cycle in_ready=0 and out_valid=0, so no handshake completes and no entry is silently lost.
  - Flush while EMPTY has no effect.
- occupancy: EMPTY=0, HALF=1, FULL=2.
- Counters:
  - stall_cnt increments when out_valid & ~out_ready.
  - bubble_cnt increments when ~out_valid & out_ready.
  - Both saturate at all-ones with no wrap.
  - Only reset clears them; flush does not.
  - Flush cycles count as bubble when out_ready=1.
- Simultaneous events:
  - in_fire and out_fire in the same cycle follow the transitions above.
  - Ordering is strictly FIFO: skid data is never presented ahead of main data.

Test Plan:
1. Streaming: reset, then out_ready=1 and in_valid=1 with in_data=1,2,3,4 on consecutive cycles → out_data=1,2,3,4 on consecutive cycles, each one cycle after acceptance; occupancy stays 1; stall_cnt=0.
2. Backpressure (SKID=1): push 0xA, 0xB with out_ready=0 → occupancy=2 and in_ready=0 from the next cycle; 0xC held at input. Then out_ready=1 → outputs 0xA, 0xB, 0xC in order with no loss or duplication; stall_cnt=2 per stalled cycle count.
3. Flush: state FULL holding 0x11, 0x22 with in_valid=1, in_data=0x33, assert flush one cycle → that cycle out_valid=0 and in_ready=0; next cycle occupancy=0. With flush deasserted, 0x33 is accepted and is the next output; 0x11 and 0x22 never appear.
4. SKID=0 instance: out_ready=0 with main full → in_ready=0 in the same cycle. Raise out_ready → in_ready=1 combinationally, with simultaneous in/out fire and occupancy staying 1.
5. Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays at 15. A flush does not clear it; sys_rst=0 for one edge does → 0.
6. Reset mid-operation: FULL state, then sys_rst=0 for one edge → out_valid=0, out_data=0, occupancy=0, in_ready=1 next cycle; no held entry reappears after reset releases.
